stream_packer: RTL and testbench
================================

Name: stream_packer

Overview:
- Parametrised successor to the compression-path output aligner.
- Packs variable-length compressed byte chunks into dense OUT_BYTES-wide words, with a residual carry buffer and valid/ready handshakes on both sides.
- Uncompressed and header beats bypass packing, with their tag stripped.
- Sits between the compressor core and the AXI-stream output stage. It adds backpressure and partial-word flush, which the previous aligner lacked.

Parameters:
- IN_BYTES, 34, input data bytes per beat; includes the tag.
- TAG_WIDTH, 16, tag bits stripped from the LSBs of bypass beats.
- OUT_BYTES, 32, output word bytes.
- LEN_WIDTH, 8, width of the valid-byte count on input.
- BUF_BYTES, 2*OUT_BYTES+IN_BYTES, residual buffer capacity in bytes.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  packer accepts beat this cycle.
- in_data  in  IN_BYTES*8  chunk; valid bytes are LSB-aligned.
- in_len  in  LEN_WIDTH  valid byte count, 0..IN_BYTES; ignored for bypass beats.
- in_last  in  1  last beat of frame.
- in_comp  in  1  1 = compressed chunk (pack); 0 = raw (bypass).
- in_header  in  1  1 = header beat (bypass).
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts.
- out_data  out  OUT_BYTES*8  packed word; unused upper bytes are zero.
- out_bytes  out  $clog2(OUT_BYTES+1)  valid bytes in out_data.
- out_last  out  1  final word of frame.

Behaviour:
- Reset (asynchronous, active-high):
  - fill=0, state=PACK.
  - out_valid=0, out_data=0, out_bytes=0, out_last=0.
  - in_ready=0 while reset is asserted; in_ready=1 on the first cycle after release.
- Transfers occur on valid&ready only.
- Output register: out_* hold stable while out_valid&!out_ready.
- Latency: one cycle from input accept to out_valid for a full word; 1-cycle bubble-free throughput when in_len>=OUT_BYTES.
- Packing (in_comp=1, in_header=0):
  - Chunk is byte-shifted left by fill; fill += in_len.
  - When fill>=OUT_BYTES and the output register is free, emit the low OUT_BYTES bytes, shift the buffer down, fill -= OUT_BYTES.
- in_ready = (state==PACK) && (fill + IN_BYTES <= BUF_BYTES after this cycle's emission).
- in_len=0 beat: accepted; no data change. If it carries in_last, it triggers the flush.
- in_len>IN_BYTES: clamped to IN_BYTES.
- States:
  - PACK: normal.
    - Accepted beat with in_last=1 -> FLUSH.
    - Accepted bypass beat with fill>0 -> DRAIN.
    - Accepted bypass beat with fill==0 -> BYP.
  - FLUSH: emit full words, then one final partial word (out_bytes=fill, out_last=1). If fill==0 when the last beat arrives, the last emitted word carries out_last=1 instead. Then fill=0 -> PACK.
  - DRAIN: emit the residual as a partial word with out_last=0 -> BYP.
  - BYP: emit bypass word -> PACK.
    - out_data = in_data >> TAG_WIDTH, truncated to OUT_BYTES.
    - out_bytes = OUT_BYTES; out_last = in_last.
- Bypass beat latching: the beat is captured in a one-entry side register at accept; in_ready=0 during DRAIN and BYP.
- Simultaneous emit and accept in the same cycle are legal; fill arithmetic uses post-emission fill.
- Reset mid-frame discards the residual; no partial word is emitted.
- Width rule: fill is $clog2(BUF_BYTES+1) bits; never exceeds BUF_BYTES (assertion).

Optional Feature:
- Macro: PACKER_STATS_EN.
- Defined: adds outputs stat_words (32b), stat_bytes (32b) and stat_stall (32b).
  - stat_words counts output handshakes.
  - stat_bytes sums out_bytes.
  - stat_stall counts cycles of in_valid&!in_ready.
  - All three saturate at 2^32-1 and are cleared by reset.
- Undefined: ports and counters are absent; no other behaviour changes.

Decomposition:
- Package packer_pkg holds:
  - state enum {PACK, FLUSH, DRAIN, BYP}.
  - Width constants FILL_W and OBYTES_W derived from the parameters.
  - Helper function to clamp in_len.
- One sub-module: byte_shifter, a parametrised byte-granular barrel shifter (data, shift amount in bytes, direction). It is instantiated for the insert shift and the downshift.

Test Plan:
- Four compressed beats, in_len=16 each, out_ready=1 -> two full words of 32 bytes with correct byte order; fill=0 at end; out_last=0.
- Beats of len 20, 20, 5 with last on the third -> full word (32B), then partial word out_bytes=13, out_last=1.
- Compressed len 10, then raw beat with in_comp=0 -> partial word out_bytes=10, out_last=0; then the bypass word equal to in_data>>16 with out_bytes=32.
- out_ready held 0 for 10 cycles while beats of len 34 stream in -> in_ready drops once fill+34>BUF_BYTES; no data lost; order preserved after release.
- Assert reset for 1 cycle mid-frame with fill=7 -> out_valid=0 immediately; next frame's first word contains no stale bytes.
- With PACKER_STATS_EN, run the scenario 2 stimulus (beats of len 20, 20, 5 with last on the third) -> stat_words=2, stat_bytes=45, stat_stall=0.

Source files
------------

// File: rtl/packer_pkg.sv
// Shared types, width constants and the input-length clamp for stream_packer.
package packer_pkg;

  localparam int IN_BYTES_DEF  = 34;
  localparam int OUT_BYTES_DEF = 32;
  localparam int BUF_BYTES_DEF = 2 * OUT_BYTES_DEF + IN_BYTES_DEF;
  localparam int FILL_W        = $clog2(BUF_BYTES_DEF + 1);
  localparam int OBYTES_W      = $clog2(OUT_BYTES_DEF + 1);

  typedef enum logic [1:0] {
    PACK  = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2,
    BYP   = 2'd3
  } state_e;

  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    if (len > max_len) begin
      return max_len;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/byte_shifter.sv
// Byte-granular barrel shifter: right_i=0 shifts toward the MSBs, right_i=1 toward the LSBs.
module byte_shifter #(
  parameter int NBYTES = 4,
  parameter int SHW    = 2
) (
  input  logic [NBYTES*8-1:0] data_i,
  input  logic [SHW-1:0]      shift_i,
  input  logic                right_i,
  output logic [NBYTES*8-1:0] data_o
);

  logic [SHW+2:0] bits_s;

  assign bits_s = {shift_i, 3'b000};
  assign data_o = right_i ? (data_i >> bits_s) : (data_i << bits_s);

endmodule

// File: rtl/stream_packer.sv
// Packs variable-length compressed chunks into OUT_BYTES words; raw/header beats bypass with the tag stripped.
// Optional counters stat_words/stat_bytes/stat_stall are built when PACKER_STATS_EN is defined.
module stream_packer
  import packer_pkg::*;
#(
  parameter int IN_BYTES  = 34,
  parameter int TAG_WIDTH = 16,
  parameter int OUT_BYTES = 32,
  parameter int LEN_WIDTH = 8,
  parameter int BUF_BYTES = 2 * OUT_BYTES + IN_BYTES
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [IN_BYTES*8-1:0]          in_data,
  input  logic [LEN_WIDTH-1:0]           in_len,
  input  logic                           in_last,
  input  logic                           in_comp,
  input  logic                           in_header,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_BYTES*8-1:0]         out_data,
  output logic [$clog2(OUT_BYTES+1)-1:0] out_bytes,
  output logic                           out_last
`ifdef PACKER_STATS_EN
  ,
  output logic [31:0]                    stat_words,
  output logic [31:0]                    stat_bytes,
  output logic [31:0]                    stat_stall
`endif
);

  localparam int FW = $clog2(BUF_BYTES + 1);
  localparam int OW = $clog2(OUT_BYTES + 1);
  // Merge window holds a full buffer plus one incoming chunk before the emit shift.
  localparam int MB = BUF_BYTES + IN_BYTES;
  localparam int MW = MB * 8;
  localparam int SW = $clog2(MB + 1);
  localparam logic [FW-1:0] OUT_F  = FW'(OUT_BYTES);
  localparam logic [FW-1:0] ROOM_F = FW'(BUF_BYTES - IN_BYTES);
  localparam logic [SW-1:0] OUT_S  = SW'(OUT_BYTES);
  localparam logic [OW-1:0] OUT_O  = OW'(OUT_BYTES);

  state_e                 state_q, state_d;
  logic [FW-1:0]          fill_q, fill_d, fill_post_s, len_s;
  logic [SW-1:0]          fill_m_s;
  logic [MW-1:0]          buf_q, buf_d, ins_s, merged_s, down_s;
  logic [IN_BYTES*8-1:0]  data_m_s;
  logic                   alive_q;
  logic                   out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [OUT_BYTES*8-1:0] out_data_q, out_data_d, byp_data_q, byp_data_d;
  logic [OW-1:0]          out_bytes_q, out_bytes_d;
  logic                   byp_last_q, byp_last_d;
  logic                   is_byp_s, out_free_s, emit_pre_s, accept_s, acc_comp_s, emit_full_s;

  assign len_s      = FW'(clamp_len(32'(in_len), 32'(IN_BYTES)));
  assign data_m_s   = in_data & ~({(IN_BYTES*8){1'b1}} << {len_s, 3'b000});
  assign is_byp_s   = !in_comp || in_header;
  assign out_free_s = !out_valid_q || out_ready;
  // Room check uses the emission that fill_q alone guarantees, keeping in_ready free of in_valid.
  assign emit_pre_s  = (state_q == PACK) && (fill_q >= OUT_F) && out_free_s;
  assign fill_post_s = emit_pre_s ? (fill_q - OUT_F) : fill_q;
  assign in_ready    = alive_q && (state_q == PACK) && (fill_post_s <= ROOM_F);
  assign accept_s    = in_valid && in_ready;
  assign acc_comp_s  = accept_s && !is_byp_s;
  assign merged_s    = buf_q | (acc_comp_s ? ins_s : '0);
  assign fill_m_s    = SW'(fill_q) + (acc_comp_s ? SW'(len_s) : '0);
  assign emit_full_s = (fill_m_s >= OUT_S) && out_free_s;

  byte_shifter #(.NBYTES(MB), .SHW(SW)) u_insert (
    .data_i  ({{((MB-IN_BYTES)*8){1'b0}}, data_m_s}),
    .shift_i (SW'(fill_q)),
    .right_i (1'b0),
    .data_o  (ins_s)
  );

  byte_shifter #(.NBYTES(MB), .SHW(SW)) u_down (
    .data_i  (merged_s),
    .shift_i (OUT_S),
    .right_i (1'b1),
    .data_o  (down_s)
  );

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    buf_d       = buf_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_bytes_d = out_bytes_q;
    out_last_d  = out_last_q;
    byp_data_d  = byp_data_q;
    byp_last_d  = byp_last_q;
    case (state_q)
      PACK: begin
        if (emit_full_s) begin
          out_valid_d = 1'b1;
          out_data_d  = merged_s[OUT_BYTES*8-1:0];
          out_bytes_d = OUT_O;
          out_last_d  = 1'b0;
          buf_d       = down_s;
          fill_d      = FW'(fill_m_s - OUT_S);
        end else if (acc_comp_s) begin
          buf_d  = merged_s;
          fill_d = FW'(fill_m_s);
        end else begin
          fill_d = fill_q;
        end
        if (accept_s) begin
          if (is_byp_s) begin
            byp_data_d = in_data[TAG_WIDTH +: OUT_BYTES*8];
            byp_last_d = in_last;
            state_d    = (fill_d != '0) ? DRAIN : BYP;
          end else if (in_last) begin
            // Nothing left to flush: tag the word just emitted or still waiting in the output register.
            if (fill_d != '0) begin
              state_d = FLUSH;
            end else if (out_valid_d) begin
              out_last_d = 1'b1;
            end else begin
              state_d = PACK;
            end
          end else begin
            state_d = PACK;
          end
        end else begin
          state_d = PACK;
        end
      end
      FLUSH, DRAIN: begin
        if (out_free_s) begin
          out_valid_d = 1'b1;
          out_data_d  = buf_q[OUT_BYTES*8-1:0];
          if (fill_q > OUT_F) begin
            out_bytes_d = OUT_O;
            out_last_d  = 1'b0;
            buf_d       = down_s;
            fill_d      = fill_q - OUT_F;
          end else begin
            out_bytes_d = OW'(fill_q);
            out_last_d  = (state_q == FLUSH);
            buf_d       = '0;
            fill_d      = '0;
            state_d     = (state_q == FLUSH) ? PACK : BYP;
          end
        end else begin
          state_d = state_q;
        end
      end
      BYP: begin
        if (out_free_s) begin
          out_valid_d = 1'b1;
          out_data_d  = byp_data_q;
          out_bytes_d = OUT_O;
          out_last_d  = byp_last_q;
          state_d     = PACK;
        end else begin
          state_d = BYP;
        end
      end
      default: state_d = PACK;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= PACK;
      fill_q      <= '0;
      buf_q       <= '0;
      alive_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_bytes_q <= '0;
      out_last_q  <= 1'b0;
      byp_data_q  <= '0;
      byp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      buf_q       <= buf_d;
      alive_q     <= 1'b1;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_bytes_q <= out_bytes_d;
      out_last_q  <= out_last_d;
      byp_data_q  <= byp_data_d;
      byp_last_q  <= byp_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_bytes = out_bytes_q;
  assign out_last  = out_last_q;

  a_fill_bound: assert property (@(posedge clk) disable iff (reset) fill_q <= FW'(BUF_BYTES));

`ifdef PACKER_STATS_EN
  logic [31:0] words_q, bytes_q, stall_q;
  logic [32:0] bytes_sum_s;

  assign bytes_sum_s = {1'b0, bytes_q} + 33'(out_bytes_q);

  // Saturating activity counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      words_q <= '0;
      bytes_q <= '0;
      stall_q <= '0;
    end else begin
      if (out_valid_q && out_ready && (words_q != 32'hFFFF_FFFF)) words_q <= words_q + 32'd1;
      if (out_valid_q && out_ready) bytes_q <= bytes_sum_s[32] ? 32'hFFFF_FFFF : bytes_sum_s[31:0];
      if (in_valid && !in_ready && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
    end
  end

  assign stat_words = words_q;
  assign stat_bytes = bytes_q;
  assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_stream_packer.sv
// Self-checking bench for stream_packer: beat table, byte-stream scoreboard, stall and reset sequences.
module tb_stream_packer;

  localparam int INB  = 34;
  localparam int OUTB = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid, in_ready, in_last, in_comp, in_header;
  logic [INB*8-1:0]  in_data;
  logic [7:0]     in_len;
  logic           out_valid, out_ready, out_last;
  logic [OUTB*8-1:0] out_data;
  logic [5:0]     out_bytes;
`ifdef PACKER_STATS_EN
  logic [31:0]    stat_words, stat_bytes, stat_stall;
`endif

  stream_packer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_len    (in_len),
    .in_last   (in_last),
    .in_comp   (in_comp),
    .in_header (in_header),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_bytes (out_bytes),
    .out_last  (out_last)
`ifdef PACKER_STATS_EN
    ,
    .stat_words(stat_words),
    .stat_bytes(stat_bytes),
    .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] data;
    int           bytes;
    bit           last;
  } exp_t;

  typedef struct {
    int scen;
    bit comp;
    bit hdr;
    int len;
    bit last;
  } vec_t;

  exp_t     exp_q[$];
  bit [7:0] pend[$];
  vec_t     vecs[14];
  int       exp_words[6];
  int       checks = 0;
  int       failures = 0;
  int       rx_words = 0;
  bit       rand_mode = 1'b0;
  bit       hold_ready = 1'b0;
  bit [7:0] seq = 8'd0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_word(input int n, input bit last);
    exp_t e;
    e.data = '0;
    for (int i = 0; i < n; i++) e.data[i*8 +: 8] = pend.pop_front();
    e.bytes = n;
    e.last  = last;
    exp_q.push_back(e);
  endtask

  // Reference: byte queue, words cut at 32 bytes, residual flushed on last or before a bypass word.
  task automatic model_accept(input logic [INB*8-1:0] d, input bit comp, input bit hdr,
                              input int len, input bit last);
    exp_t e;
    int   l;
    if (!comp || hdr) begin
      while (pend.size() > 0) push_word((pend.size() > OUTB) ? OUTB : pend.size(), 1'b0);
      e.data  = d[INB*8-1:16];
      e.bytes = OUTB;
      e.last  = last;
      exp_q.push_back(e);
    end else begin
      l = (len > INB) ? INB : len;
      for (int i = 0; i < l; i++) pend.push_back(d[i*8 +: 8]);
      while (pend.size() >= OUTB) push_word(OUTB, 1'b0);
      if (last) begin
        if (pend.size() > 0) begin
          push_word(pend.size(), 1'b1);
        end else if (exp_q.size() > 0) begin
          e = exp_q.pop_back();
          e.last = 1'b1;
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic make_beat(input bit comp, input bit hdr, input int len, output logic [INB*8-1:0] d);
    for (int b = 0; b < INB; b++) begin
      if (comp && !hdr && b < len) begin
        d[b*8 +: 8] = seq;
        seq = seq + 8'd1;
      end else begin
        d[b*8 +: 8] = 8'($urandom_range(0, 255));
      end
    end
  endtask

  task automatic update_ready();
    if (hold_ready) out_ready = 1'b0;
    else if (rand_mode) out_ready = 1'($urandom_range(0, 1));
    else out_ready = 1'b1;
  endtask

  task automatic send_beat(input bit comp, input bit hdr, input int len, input bit last);
    logic [INB*8-1:0] d;
    bit acc;
    make_beat(comp, hdr, len, d);
    in_data = d; in_comp = comp; in_header = hdr; in_len = 8'(len); in_last = last;
    in_valid = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 200 && !acc; c++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        model_accept(d, comp, hdr, len, last);
      end
      @(posedge clk); #1;
      update_ready();
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++; failures++;
      $display("FAIL accept_timeout: got no in_ready expected accept within 200 cycles");
    end
  endtask

  task automatic wait_drain(input string nm, input int expw, input int start);
    for (int c = 0; c < 400 && (exp_q.size() > 0 || out_valid); c++) begin
      @(posedge clk); #1;
      update_ready();
    end
    chk({nm, "_pending"}, 256'(exp_q.size()), 256'd0);
    chk({nm, "_words"}, 256'(rx_words - start), 256'(expw));
  endtask

  task automatic run_scen(input int s);
    int start;
    start = rx_words;
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].scen == s) begin
        send_beat(vecs[i].comp, vecs[i].hdr, vecs[i].len, vecs[i].last);
        if (s == 4 && !rand_mode) begin
          chk("latency_valid", 256'(out_valid), 256'd1);
          chk("latency_last", 256'(out_last), 256'd1);
        end
      end
    end
    wait_drain($sformatf("scen%0d", s), exp_words[s], start);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        rx_words++;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_word: got bytes=%0d expected no word", out_bytes);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_bytes", 256'(out_bytes), 256'(e.bytes));
          chk("out_last", 256'(out_last), 256'(e.last));
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected end before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [INB*8-1:0] d;
    int n_acc, b, start;
    vecs[0]  = '{0, 1'b1, 1'b0, 16, 1'b0};
    vecs[1]  = '{0, 1'b1, 1'b0, 16, 1'b0};
    vecs[2]  = '{0, 1'b1, 1'b0, 16, 1'b0};
    vecs[3]  = '{0, 1'b1, 1'b0, 16, 1'b0};
    vecs[4]  = '{1, 1'b1, 1'b0, 20, 1'b0};
    vecs[5]  = '{1, 1'b1, 1'b0, 20, 1'b0};
    vecs[6]  = '{1, 1'b1, 1'b0, 5,  1'b1};
    vecs[7]  = '{2, 1'b1, 1'b0, 10, 1'b0};
    vecs[8]  = '{2, 1'b0, 1'b0, 0,  1'b0};
    vecs[9]  = '{3, 1'b1, 1'b1, 0,  1'b0};
    vecs[10] = '{3, 1'b1, 1'b0, 40, 1'b1};
    vecs[11] = '{4, 1'b1, 1'b0, 32, 1'b1};
    vecs[12] = '{5, 1'b1, 1'b0, 5,  1'b0};
    vecs[13] = '{5, 1'b1, 1'b0, 0,  1'b1};
    exp_words = '{2, 2, 2, 3, 1, 1};

    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_len = 8'd0;
    in_last = 1'b0; in_comp = 1'b0; in_header = 1'b0; out_ready = 1'b1;
    fork
      monitor();
    join_none
    #1;
    chk("rst_out_valid", 256'(out_valid), 256'd0);
    chk("rst_out_data", out_data, 256'd0);
    chk("rst_out_bytes", 256'(out_bytes), 256'd0);
    chk("rst_out_last", 256'(out_last), 256'd0);
    chk("rst_in_ready", 256'(in_ready), 256'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 256'(in_ready), 256'd1);

    run_scen(1);
`ifdef PACKER_STATS_EN
    chk("stat_words", 256'(stat_words), 256'd2);
    chk("stat_bytes", 256'(stat_bytes), 256'd45);
    chk("stat_stall", 256'(stat_stall), 256'd0);
`endif

    for (int s = 0; s < 6; s++) run_scen(s);
    rand_mode = 1'b1;
    for (int s = 0; s < 6; s++) run_scen(s);
    rand_mode = 1'b0;
    update_ready();

    // Backpressure: out_ready low for 10 cycles with full-width chunks streaming.
    start = rx_words;
    hold_ready = 1'b1; update_ready();
    n_acc = 0; b = 0;
    make_beat(1'b1, 1'b0, INB, d);
    in_data = d; in_comp = 1'b1; in_header = 1'b0; in_len = 8'(INB); in_last = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(d, 1'b1, 1'b0, INB, 1'b0);
        n_acc++; b++;
      end
      @(posedge clk); #1;
      if (b < 6) begin
        if (in_ready == 1'b0 && c > 0) begin end
        make_beat(1'b1, 1'b0, (n_acc == b) ? INB : INB, d);
      end
      in_data = d;
    end
    chk("stall_accepts", 256'(n_acc), 256'd3);
    chk("stall_in_ready", 256'(in_ready), 256'd0);
    hold_ready = 1'b0; update_ready();
    for (int c = 0; c < 100 && b < 6; c++) begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(d, 1'b1, 1'b0, INB, 1'b0);
        b++;
        @(posedge clk); #1;
        if (b < 6) make_beat(1'b1, 1'b0, INB, d);
        in_data = d;
      end else begin
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    chk("stall_all_sent", 256'(b), 256'd6);
    send_beat(1'b1, 1'b0, 0, 1'b1);
    wait_drain("stall", 7, start);

    // Reset in the middle of a frame holding 7 residual bytes.
    send_beat(1'b1, 1'b0, 7, 1'b0);
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", 256'(out_valid), 256'd0);
    chk("midrst_in_ready", 256'(in_ready), 256'd0);
    exp_q.delete();
    pend.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_release_ready", 256'(in_ready), 256'd1);
    start = rx_words;
    send_beat(1'b1, 1'b0, 32, 1'b1);
    wait_drain("midrst", 1, start);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
